// File: rtl/qspi_arb_pkg.sv
// Shared types and constants for the QSPI request arbiter: FSM state encoding,
// request-source codes and parameter defaults.
package qspi_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_BUSY  = 2'd2
    } arb_state_e;

    localparam logic SRC_DCHAN = 1'b0;
    localparam logic SRC_CCHAN = 1'b1;

    localparam int TIMEOUT_CYC_DEF = 4096;
    localparam int STARVE_MAX_DEF  = 15;

    // ISSUE and BUSY both count as holding the control port.
    function automatic logic arb_is_active(input arb_state_e st);
        return (st == ARB_ISSUE) || (st == ARB_BUSY);
    endfunction

endpackage

// File: rtl/qspi_arb_watchdog.sv
// BUSY-phase watchdog: cleared by start, counts while run is high, and flags
// expire on the cycle the count reaches limit-1. A limit of zero never expires.
module qspi_arb_watchdog (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        run,
    input  logic [15:0] limit,
    output logic        expire
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count and expiry decode.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = 16'd0;
        end else if (run) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
        expire = run && (limit != 16'd0) && (cnt_q == (limit - 16'd1));
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/qspi_req_arbiter.sv
// Arbitrates the dchan and cchan request ports onto the single control-level request port.
// Optional feature macro: QSPI_ARB_STARVE_EN (bounded cchan priority, dchan anti-starvation).
module qspi_req_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int STARVE_MAX  = STARVE_MAX_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_dchan_req_valid,
    output logic        io_dchan_req_ready,
    input  logic [7:0]  io_dchan_req_data_size,
    input  logic [7:0]  io_dchan_req_data_burstlen,
    input  logic [7:0]  io_dchan_req_inst,
    input  logic [23:0] io_dchan_req_addr,
    input  logic        io_cchan_req_valid,
    output logic        io_cchan_req_ready,
    input  logic [7:0]  io_cchan_req_data_size,
    input  logic [7:0]  io_cchan_req_data_burstlen,
    input  logic [7:0]  io_cchan_req_inst,
    input  logic [23:0] io_cchan_req_addr,
    output logic        io_ctrl_req_valid,
    input  logic        io_ctrl_req_ready,
    output logic [7:0]  io_ctrl_req_data_size,
    output logic [7:0]  io_ctrl_req_data_burstlen,
    output logic [7:0]  io_ctrl_req_inst,
    output logic [23:0] io_ctrl_req_addr,
    output logic        io_ctrl_req_src,
    input  logic        io_ctrl_done,
    input  logic        io_tdata_lock,
    output logic        io_arb_busy,
    output logic        io_arb_timeout
);

    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYC);

    arb_state_e  state_q, state_d;
    logic [7:0]  size_q, size_d;
    logic [7:0]  burstlen_q, burstlen_d;
    logic [7:0]  inst_q, inst_d;
    logic [23:0] addr_q, addr_d;
    logic        src_q, src_d;

    logic        dchan_elig;
    logic        grant_c;
    logic        grant_d;
    logic        wd_start;
    logic        wd_run;
    logic        wd_expire;

`ifdef QSPI_ARB_STARVE_EN
    logic [3:0]  starve_q, starve_d;
    logic        starve_force;

    // IDLE arbitration with a forced dchan win once it has lost STARVE_MAX times.
    always_comb begin
        dchan_elig   = io_dchan_req_valid && !io_tdata_lock;
        starve_force = (starve_q >= 4'(STARVE_MAX));
        grant_c      = (state_q == ARB_IDLE) && io_cchan_req_valid
                       && !(starve_force && dchan_elig);
        grant_d      = (state_q == ARB_IDLE) && dchan_elig && !grant_c;
    end

    // Starvation count: bumped when an eligible dchan loses, cleared by a dchan grant.
    always_comb begin
        starve_d = starve_q;
        if (grant_d) begin
            starve_d = 4'd0;
        end else if (grant_c && dchan_elig && (starve_q != 4'hF)) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // IDLE arbitration with strict cchan priority.
    always_comb begin
        dchan_elig = io_dchan_req_valid && !io_tdata_lock;
        grant_c    = (state_q == ARB_IDLE) && io_cchan_req_valid;
        grant_d    = (state_q == ARB_IDLE) && dchan_elig && !io_cchan_req_valid;
    end
`endif

    // Next state, request capture and handshake outputs.
    always_comb begin
        state_d            = state_q;
        size_d             = size_q;
        burstlen_d         = burstlen_q;
        inst_d             = inst_q;
        addr_d             = addr_q;
        src_d              = src_q;
        io_dchan_req_ready = 1'b0;
        io_cchan_req_ready = 1'b0;
        io_ctrl_req_valid  = 1'b0;
        io_arb_timeout     = 1'b0;
        wd_start           = 1'b0;
        wd_run             = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (grant_c) begin
                    io_cchan_req_ready = 1'b1;
                    size_d             = io_cchan_req_data_size;
                    burstlen_d         = io_cchan_req_data_burstlen;
                    inst_d             = io_cchan_req_inst;
                    addr_d             = io_cchan_req_addr;
                    src_d              = SRC_CCHAN;
                    state_d            = ARB_ISSUE;
                end else if (grant_d) begin
                    io_dchan_req_ready = 1'b1;
                    size_d             = io_dchan_req_data_size;
                    burstlen_d         = io_dchan_req_data_burstlen;
                    inst_d             = io_dchan_req_inst;
                    addr_d             = io_dchan_req_addr;
                    src_d              = SRC_DCHAN;
                    state_d            = ARB_ISSUE;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                // A done pulse here belongs to nothing we issued, so it is ignored.
                io_ctrl_req_valid = 1'b1;
                if (io_ctrl_req_ready) begin
                    wd_start = 1'b1;
                    state_d  = ARB_BUSY;
                end else begin
                    state_d = ARB_ISSUE;
                end
            end
            ARB_BUSY: begin
                wd_run = 1'b1;
                if (io_ctrl_done) begin
                    state_d = ARB_IDLE;
                end else if (wd_expire) begin
                    io_arb_timeout = 1'b1;
                    state_d        = ARB_IDLE;
                end else begin
                    state_d = ARB_BUSY;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // FSM and captured-request registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            size_q     <= 8'd0;
            burstlen_q <= 8'd0;
            inst_q     <= 8'd0;
            addr_q     <= 24'd0;
            src_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            burstlen_q <= burstlen_d;
            inst_q     <= inst_d;
            addr_q     <= addr_d;
            src_q      <= src_d;
        end
    end

    qspi_arb_watchdog u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .start  (wd_start),
        .run    (wd_run),
        .limit  (WD_LIMIT),
        .expire (wd_expire)
    );

    assign io_ctrl_req_data_size     = size_q;
    assign io_ctrl_req_data_burstlen = burstlen_q;
    assign io_ctrl_req_inst          = inst_q;
    assign io_ctrl_req_addr          = addr_q;
    assign io_ctrl_req_src           = src_q;
    assign io_arb_busy               = arb_is_active(state_q);

endmodule

// File: tb/tb_qspi_req_arbiter.sv
// Directed scoreboard bench for qspi_req_arbiter (TIMEOUT_CYC=8, STARVE_MAX=3).
module tb_qspi_req_arbiter;

    typedef struct packed {
        logic        src;
        logic [7:0]  size;
        logic [7:0]  burst;
        logic [7:0]  inst;
        logic [23:0] addr;
    } req_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_dchan_req_valid, io_dchan_req_ready;
    logic [7:0]  io_dchan_req_data_size, io_dchan_req_data_burstlen, io_dchan_req_inst;
    logic [23:0] io_dchan_req_addr;
    logic        io_cchan_req_valid, io_cchan_req_ready;
    logic [7:0]  io_cchan_req_data_size, io_cchan_req_data_burstlen, io_cchan_req_inst;
    logic [23:0] io_cchan_req_addr;
    logic        io_ctrl_req_valid, io_ctrl_req_ready;
    logic [7:0]  io_ctrl_req_data_size, io_ctrl_req_data_burstlen, io_ctrl_req_inst;
    logic [23:0] io_ctrl_req_addr;
    logic        io_ctrl_req_src, io_ctrl_done, io_tdata_lock, io_arb_busy, io_arb_timeout;

    int   checks = 0;
    int   errors = 0;
    req_t sb[$];
    req_t exp_r;
    logic exp_src[5];

    always #5 clock = ~clock;

    qspi_req_arbiter #(.TIMEOUT_CYC(8), .STARVE_MAX(3)) dut (
        .clock                      (clock),
        .reset                      (reset),
        .io_dchan_req_valid         (io_dchan_req_valid),
        .io_dchan_req_ready         (io_dchan_req_ready),
        .io_dchan_req_data_size     (io_dchan_req_data_size),
        .io_dchan_req_data_burstlen (io_dchan_req_data_burstlen),
        .io_dchan_req_inst          (io_dchan_req_inst),
        .io_dchan_req_addr          (io_dchan_req_addr),
        .io_cchan_req_valid         (io_cchan_req_valid),
        .io_cchan_req_ready         (io_cchan_req_ready),
        .io_cchan_req_data_size     (io_cchan_req_data_size),
        .io_cchan_req_data_burstlen (io_cchan_req_data_burstlen),
        .io_cchan_req_inst          (io_cchan_req_inst),
        .io_cchan_req_addr          (io_cchan_req_addr),
        .io_ctrl_req_valid          (io_ctrl_req_valid),
        .io_ctrl_req_ready          (io_ctrl_req_ready),
        .io_ctrl_req_data_size      (io_ctrl_req_data_size),
        .io_ctrl_req_data_burstlen  (io_ctrl_req_data_burstlen),
        .io_ctrl_req_inst           (io_ctrl_req_inst),
        .io_ctrl_req_addr           (io_ctrl_req_addr),
        .io_ctrl_req_src            (io_ctrl_req_src),
        .io_ctrl_done               (io_ctrl_done),
        .io_tdata_lock              (io_tdata_lock),
        .io_arb_busy                (io_arb_busy),
        .io_arb_timeout             (io_arb_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_d(input logic v, input logic [7:0] s, input logic [7:0] b,
                           input logic [7:0] i, input logic [23:0] a);
        io_dchan_req_valid = v; io_dchan_req_data_size = s;
        io_dchan_req_data_burstlen = b; io_dchan_req_inst = i; io_dchan_req_addr = a;
    endtask

    task automatic drive_c(input logic v, input logic [7:0] s, input logic [7:0] b,
                           input logic [7:0] i, input logic [23:0] a);
        io_cchan_req_valid = v; io_cchan_req_data_size = s;
        io_cchan_req_data_burstlen = b; io_cchan_req_inst = i; io_cchan_req_addr = a;
    endtask

    // Wait (bounded) for a request on the control port and score it.
    task automatic expect_issue(input string tag);
        req_t e;
        int   n = 0;
        while (io_ctrl_req_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 64'(io_ctrl_req_valid), 64'd1);
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_sb: observed=request expected=empty scoreboard", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_src"},   64'(io_ctrl_req_src),           64'(e.src));
            chk({tag, "_size"},  64'(io_ctrl_req_data_size),     64'(e.size));
            chk({tag, "_burst"}, 64'(io_ctrl_req_data_burstlen), 64'(e.burst));
            chk({tag, "_inst"},  64'(io_ctrl_req_inst),          64'(e.inst));
            chk({tag, "_addr"},  64'(io_ctrl_req_addr),          64'(e.addr));
        end
    endtask

    task automatic finish_txn(input string tag);
        io_ctrl_req_ready = 1'b1;
        tick();
        io_ctrl_req_ready = 1'b0;
        chk({tag, "_busy_in_busy"}, 64'(io_arb_busy), 64'd1);
        chk({tag, "_valid_in_busy"}, 64'(io_ctrl_req_valid), 64'd0);
        io_ctrl_done = 1'b1;
        tick();
        io_ctrl_done = 1'b0;
        chk({tag, "_idle_after_done"}, 64'(io_arb_busy), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        io_ctrl_req_ready = 1'b0; io_ctrl_done = 1'b0; io_tdata_lock = 1'b0;
        drive_d(1'b0, 8'h00, 8'h00, 8'h00, 24'h0);
        drive_c(1'b0, 8'h00, 8'h00, 8'h00, 24'h0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_valid", 64'(io_ctrl_req_valid), 64'd0);
        chk("rst_busy",  64'(io_arb_busy),       64'd0);
        chk("rst_src",   64'(io_ctrl_req_src),   64'd0);
        chk("rst_inst",  64'(io_ctrl_req_inst),  64'd0);
        chk("rst_addr",  64'(io_ctrl_req_addr),  64'd0);
        chk("rst_tmo",   64'(io_arb_timeout),    64'd0);

        // 1: dchan only, latency and capture isolation.
        drive_d(1'b1, 8'h04, 8'h08, 8'h6B, 24'h001000);
        #1;
        chk("t1_dready", 64'(io_dchan_req_ready), 64'd1);
        chk("t1_cready", 64'(io_cchan_req_ready), 64'd0);
        sb.push_back('{1'b0, 8'h04, 8'h08, 8'h6B, 24'h001000});
        tick();
        drive_d(1'b0, 8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF);
        chk("t1_lat", 64'(io_ctrl_req_valid), 64'd1);
        expect_issue("t1");
        finish_txn("t1");

        // 2: both valid, cchan first, dchan in the first IDLE cycle afterwards.
        drive_c(1'b1, 8'h01, 8'h02, 8'h9F, 24'hABCDEF);
        drive_d(1'b1, 8'h03, 8'h04, 8'h0B, 24'h123456);
        #1;
        chk("t2_cready", 64'(io_cchan_req_ready), 64'd1);
        chk("t2_dready", 64'(io_dchan_req_ready), 64'd0);
        sb.push_back('{1'b1, 8'h01, 8'h02, 8'h9F, 24'hABCDEF});
        tick();
        drive_c(1'b0, 8'h00, 8'h00, 8'h00, 24'h0);
        chk("t2_dready_issue", 64'(io_dchan_req_ready), 64'd0);
        expect_issue("t2c");
        finish_txn("t2c");
        chk("t2_dready_next", 64'(io_dchan_req_ready), 64'd1);
        sb.push_back('{1'b0, 8'h03, 8'h04, 8'h0B, 24'h123456});
        tick();
        drive_d(1'b0, 8'h00, 8'h00, 8'h00, 24'h0);
        expect_issue("t2d");
        finish_txn("t2d");

        // 3: stall in ISSUE for 5 cycles; done in ISSUE is ignored.
        drive_c(1'b1, 8'h10, 8'h20, 8'h05, 24'h00BEEF);
        sb.push_back('{1'b1, 8'h10, 8'h20, 8'h05, 24'h00BEEF});
        tick();
        drive_c(1'b0, 8'h77, 8'h77, 8'h77, 24'h777777);
        io_ctrl_done = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("t3_hold_valid", 64'(io_ctrl_req_valid), 64'd1);
            chk("t3_hold_addr",  64'(io_ctrl_req_addr),  64'h00BEEF);
            tick();
        end
        expect_issue("t3");
        io_ctrl_req_ready = 1'b1;
        tick();
        io_ctrl_req_ready = 1'b0;
        io_ctrl_done = 1'b0;
        tick();
        chk("t3_busy_after_ignored_done", 64'(io_arb_busy), 64'd1);
        chk("t3_valid_busy", 64'(io_ctrl_req_valid), 64'd0);
        io_ctrl_done = 1'b1;
        tick();
        io_ctrl_done = 1'b0;
        chk("t3_idle", 64'(io_arb_busy), 64'd0);

        // 4: tdata_lock blocks dchan, and does not disturb a granted request.
        io_tdata_lock = 1'b1;
        drive_d(1'b1, 8'h02, 8'h01, 8'hEB, 24'h0A0B0C);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("t4_locked_ready", 64'(io_dchan_req_ready), 64'd0);
            chk("t4_locked_busy",  64'(io_arb_busy),        64'd0);
            tick();
        end
        io_tdata_lock = 1'b0;
        #1;
        chk("t4_unlock_ready", 64'(io_dchan_req_ready), 64'd1);
        sb.push_back('{1'b0, 8'h02, 8'h01, 8'hEB, 24'h0A0B0C});
        tick();
        drive_d(1'b0, 8'h00, 8'h00, 8'h00, 24'h0);
        io_tdata_lock = 1'b1;
        expect_issue("t4");
        finish_txn("t4");
        io_tdata_lock = 1'b0;

        // 5: watchdog expiry on the 8th BUSY cycle, then done winning on that cycle.
        for (int k = 0; k < 2; k++) begin
            drive_d(1'b1, 8'h01, 8'h01, 8'h03, 24'h000100);
            sb.push_back('{1'b0, 8'h01, 8'h01, 8'h03, 24'h000100});
            tick();
            drive_d(1'b0, 8'h00, 8'h00, 8'h00, 24'h0);
            expect_issue("t5");
            io_ctrl_req_ready = 1'b1;
            tick();
            io_ctrl_req_ready = 1'b0;
            for (int c = 1; c < 8; c++) begin
                chk("t5_no_early_tmo", 64'(io_arb_timeout), 64'd0);
                chk("t5_busy", 64'(io_arb_busy), 64'd1);
                tick();
            end
            if (k == 0) begin
                chk("t5_tmo_pulse", 64'(io_arb_timeout), 64'd1);
            end else begin
                io_ctrl_done = 1'b1;
                #1;
                chk("t5_done_wins", 64'(io_arb_timeout), 64'd0);
            end
            tick();
            io_ctrl_done = 1'b0;
            chk("t5_idle", 64'(io_arb_busy), 64'd0);
            chk("t5_tmo_clear", 64'(io_arb_timeout), 64'd0);
        end

        // 6: both always valid; grant order depends on the starvation option.
`ifdef QSPI_ARB_STARVE_EN
        exp_src = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        exp_src = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        drive_c(1'b1, 8'h0C, 8'h0C, 8'hC0, 24'hC0C0C0);
        drive_d(1'b1, 8'h0D, 8'h0D, 8'hD0, 24'hD0D0D0);
        for (int g = 0; g < 5; g++) begin
            #1;
            chk("t6_cready", 64'(io_cchan_req_ready), 64'(exp_src[g]));
            chk("t6_dready", 64'(io_dchan_req_ready), 64'(!exp_src[g]));
            if (exp_src[g]) exp_r = '{1'b1, 8'h0C, 8'h0C, 8'hC0, 24'hC0C0C0};
            else            exp_r = '{1'b0, 8'h0D, 8'h0D, 8'hD0, 24'hD0D0D0};
            sb.push_back(exp_r);
            tick();
            expect_issue("t6");
            finish_txn("t6");
        end

        // Reset while in ISSUE discards the request.
        #1;
        sb.push_back('{1'b1, 8'h0C, 8'h0C, 8'hC0, 24'hC0C0C0});
        tick();
        drive_c(1'b0, 8'h00, 8'h00, 8'h00, 24'h0);
        drive_d(1'b0, 8'h00, 8'h00, 8'h00, 24'h0);
        chk("t6_issue_before_rst", 64'(io_ctrl_req_valid), 64'd1);
        void'(sb.pop_front());
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_valid", 64'(io_ctrl_req_valid), 64'd0);
        chk("t6_rst_busy",  64'(io_arb_busy),       64'd0);
        chk("t6_rst_src",   64'(io_ctrl_req_src),   64'd0);
        chk("t6_rst_inst",  64'(io_ctrl_req_inst),  64'd0);
        chk("t6_rst_addr",  64'(io_ctrl_req_addr),  64'd0);
        chk("t6_rst_size",  64'(io_ctrl_req_data_size), 64'd0);
        tick();
        chk("t6_stays_idle", 64'(io_arb_busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
